// File: rtl/role_trace_pkg.sv
// Shared types and width helpers for the role trace packer.
package role_trace_pkg;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_REC_W     = 64;
  localparam int DEF_OUT_W     = 512;
  localparam int DEF_MAX_BEATS = 16;
  localparam int DEF_TIMEOUT   = 256;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // clog2 that never yields a zero-width vector
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/role_trace_rr_arb.sv
// Round-robin arbiter: one-hot grant among req, pointer moves past each winner.
module role_trace_rr_arb
  import role_trace_pkg::*;
#(
  parameter int N = DEF_NUM_CH
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = clog2_min1(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  pick;
  logic          found;

  // requests at or above the pointer win first, otherwise wrap to the bottom
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) hi_mask[i] = (PW'(i) >= ptr);
    pick  = (|(req & hi_mask)) ? (req & hi_mask) : req;
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && pick[i]) begin
        found  = 1'b1;
        gnt[i] = en;
        gidx   = PW'(i);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)          ptr <= '0;
    else if (en && found) ptr <= (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
  end

endmodule

// File: rtl/role_trace_packer.sv
// Trace collector: round-robin record intake, beat packing, AXI-Stream output.
// Optional ROLE_TRACE_CH_TAG_EN stamps the source channel into each slot's MSBs.
module role_trace_packer
  import role_trace_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int REC_W     = DEF_REC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NUM_CH-1:0]       s_trace_valid,
  output logic [NUM_CH-1:0]       s_trace_ready,
  input  logic [NUM_CH*REC_W-1:0] s_trace_data,
  input  logic                    flush_req,
  output logic                    m_axis_trace_tvalid,
  input  logic                    m_axis_trace_tready,
  output logic [OUT_W-1:0]        m_axis_trace_tdata,
  output logic [OUT_W/8-1:0]      m_axis_trace_tkeep,
  output logic                    m_axis_trace_tlast
);

  localparam int RPB  = OUT_W / REC_W;
  localparam int RB   = REC_W / 8;
  localparam int KW   = OUT_W / 8;
  localparam int FC_W = clog2_min1(RPB + 1);
  localparam int BC_W = clog2_min1(MAX_BEATS);
  localparam int IW   = clog2_min1(TIMEOUT + 1);

  state_e                       st, st_nxt;
  logic [NUM_CH-1:0][REC_W-1:0] rec;
  logic [RPB-1:0][REC_W-1:0]    acc, acc_nxt;
  logic [FC_W-1:0]              fcnt, fcnt_nxt;
  logic [BC_W-1:0]              bcnt;
  logic [IW-1:0]                idle;
  logic [NUM_CH-1:0]            gnt;
  logic [REC_W-1:0]             rec_sel;
  logic [KW-1:0]                keep_nxt;
  logic                         arb_en, acc_en, timeout_hit;
  logic                         flush_pend, flush_go, out_free, xfer, last_nxt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
`ifdef ROLE_TRACE_CH_TAG_EN
    localparam int CH_W = clog2_min1(NUM_CH);
    assign rec[c] = {CH_W'(c), s_trace_data[c*REC_W +: REC_W-CH_W]};
`else
    assign rec[c] = s_trace_data[c*REC_W +: REC_W];
`endif
  end

  // a flush request in the same cycle steals the grant so the record is re-offered
  assign arb_en = !areset && (st == ST_FILL) && !flush_req && (fcnt < FC_W'(RPB));

  role_trace_rr_arb #(.N(NUM_CH)) u_arb (
    .aclk   (aclk),
    .areset (areset),
    .req    (s_trace_valid),
    .en     (arb_en),
    .gnt    (gnt)
  );

  assign s_trace_ready = gnt;
  assign acc_en        = |gnt;

  always_comb begin
    rec_sel = '0;
    for (int c = 0; c < NUM_CH; c++) if (gnt[c]) rec_sel = rec[c];
    fcnt_nxt = fcnt + FC_W'(acc_en);
    acc_nxt  = acc;
    keep_nxt = '0;
    for (int k = 0; k < RPB; k++) begin
      if (acc_en && fcnt == FC_W'(k)) acc_nxt[k] = rec_sel;
      keep_nxt[k*RB +: RB] = {RB{FC_W'(k) < fcnt_nxt}};
    end
  end

  // idle only matters with a partial beat; it never coincides with an accept
  assign timeout_hit = (st == ST_FILL) && !acc_en && (fcnt != '0) &&
                       (idle == IW'(TIMEOUT - 1));
  assign flush_pend  = (st == ST_FLUSH) || flush_req || timeout_hit;
  // an empty flush with no open packet has nothing to close
  assign flush_go    = flush_pend && ((fcnt != '0) || (bcnt != '0));
  assign out_free    = !m_axis_trace_tvalid || m_axis_trace_tready;
  assign xfer        = out_free && ((fcnt_nxt == FC_W'(RPB)) || flush_go);
  assign last_nxt    = flush_pend || (bcnt == BC_W'(MAX_BEATS - 1));

  always_comb begin
    st_nxt = st;
    if (flush_pend) st_nxt = (flush_go && !xfer) ? ST_FLUSH : ST_FILL;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st   <= ST_FILL;
      acc  <= '0;
      fcnt <= '0;
      bcnt <= '0;
      idle <= '0;
    end else begin
      st <= st_nxt;
      if (xfer) begin
        acc  <= '0;
        fcnt <= '0;
        bcnt <= last_nxt ? '0 : bcnt + 1'b1;
      end else begin
        acc  <= acc_nxt;
        fcnt <= fcnt_nxt;
      end
      if (acc_en || xfer || fcnt == '0)          idle <= '0;
      else if (st == ST_FILL && !timeout_hit)    idle <= idle + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_trace_tvalid <= 1'b0;
      m_axis_trace_tdata  <= '0;
      m_axis_trace_tkeep  <= '0;
      m_axis_trace_tlast  <= 1'b0;
    end else if (xfer) begin
      m_axis_trace_tvalid <= 1'b1;
      m_axis_trace_tdata  <= acc_nxt;
      m_axis_trace_tkeep  <= keep_nxt;
      m_axis_trace_tlast  <= last_nxt;
    end else if (m_axis_trace_tready) begin
      m_axis_trace_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_role_trace_packer.sv
// Directed scoreboard bench for role_trace_packer (4 ch, 64b records, 512b beats).
module tb_role_trace_packer;

  localparam int NUM_CH    = 4;
  localparam int REC_W     = 64;
  localparam int OUT_W     = 512;
  localparam int MAX_BEATS = 4;
  localparam int TIMEOUT   = 16;
  localparam int KW        = OUT_W / 8;

  logic                    aclk = 1'b0;
  logic                    areset = 1'b0;
  logic [NUM_CH-1:0]       s_trace_valid;
  logic [NUM_CH-1:0]       s_trace_ready;
  logic [NUM_CH*REC_W-1:0] s_trace_data;
  logic                    flush_req;
  logic                    m_axis_trace_tvalid;
  logic                    m_axis_trace_tready;
  logic [OUT_W-1:0]        m_axis_trace_tdata;
  logic [KW-1:0]           m_axis_trace_tkeep;
  logic                    m_axis_trace_tlast;

  role_trace_packer #(
    .NUM_CH(NUM_CH), .REC_W(REC_W), .OUT_W(OUT_W),
    .MAX_BEATS(MAX_BEATS), .TIMEOUT(TIMEOUT)
  ) dut (
    .aclk                (aclk),
    .areset              (areset),
    .s_trace_valid       (s_trace_valid),
    .s_trace_ready       (s_trace_ready),
    .s_trace_data        (s_trace_data),
    .flush_req           (flush_req),
    .m_axis_trace_tvalid (m_axis_trace_tvalid),
    .m_axis_trace_tready (m_axis_trace_tready),
    .m_axis_trace_tdata  (m_axis_trace_tdata),
    .m_axis_trace_tkeep  (m_axis_trace_tkeep),
    .m_axis_trace_tlast  (m_axis_trace_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [KW-1:0]    k;
    logic             l;
  } beat_t;

  beat_t            exp_q[$];
  beat_t            mon_e;
  int               n_chk = 0;
  int               n_pass = 0;
  int               left[NUM_CH];
  logic [REC_W-1:0] val[NUM_CH];
  logic [OUT_W-1:0] bd;

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic push_beat(input logic [OUT_W-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    exp_q.push_back(b);
  endtask

  function automatic bit any_left();
    for (int c = 0; c < NUM_CH; c++) if (left[c] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // monitor: every accepted output beat is matched against the next expectation
  always @(negedge aclk) begin
    if (!areset && m_axis_trace_tvalid && m_axis_trace_tready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got tdata %0h tkeep %0h tlast %0b, want no beat",
                 m_axis_trace_tdata, m_axis_trace_tkeep, m_axis_trace_tlast);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_tdata", m_axis_trace_tdata, mon_e.d);
        chk("beat_tkeep", OUT_W'(m_axis_trace_tkeep), OUT_W'(mon_e.k));
        chk("beat_tlast", OUT_W'(m_axis_trace_tlast), OUT_W'(mon_e.l));
      end
    end
  end

  // drives per-channel streams; tready low for the first 'stall' cycles
  task automatic stream(input int stall, input int budget, output int cycles, output int acc_stall);
    cycles = 0;
    acc_stall = 0;
    while (any_left() && cycles < budget) begin
      for (int c = 0; c < NUM_CH; c++) begin
        s_trace_valid[c] = (left[c] > 0);
        s_trace_data[c*REC_W +: REC_W] = val[c];
      end
      m_axis_trace_tready = (cycles >= stall);
      @(negedge aclk);
      for (int c = 0; c < NUM_CH; c++) begin
        if (s_trace_valid[c] && s_trace_ready[c]) begin
          left[c]--;
          val[c]++;
          if (cycles < stall) acc_stall++;
        end
      end
      cycles++;
      @(posedge aclk); #1;
    end
    s_trace_valid = '0;
    chk("stream_completed", OUT_W'(any_left()), '0);
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    @(posedge aclk); #1;
    flush_req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    chk(name, OUT_W'(exp_q.size()), '0);
    repeat (4) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_trace_valid = '0;
    flush_req = 1'b0;
    m_axis_trace_tready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) left[c] = 0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    int cyc, acs, n;
    s_trace_valid = '1;
    s_trace_data = '0;
    flush_req = 1'b0;
    m_axis_trace_tready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin left[c] = 0; val[c] = '0; end

    #1 areset = 1'b1;
    #2;
    chk("reset_ctrl", OUT_W'({m_axis_trace_tvalid, m_axis_trace_tlast, m_axis_trace_tkeep, s_trace_ready}), '0);
    chk("reset_tdata", m_axis_trace_tdata, '0);
    s_trace_valid = '0;
    @(posedge aclk); #1 areset = 1'b0;
    @(posedge aclk); #1;

    // S1: ch0 streams 0..31 at full rate
    do_reset();
    left[0] = 32; val[0] = 64'd0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) bd[k*64 +: 64] = 64'(b*8 + k);
      push_beat(bd, '1, b == 3);
    end
    stream(0, 100, cyc, acs);
    chk("s1_cycles_for_32", OUT_W'(cyc), OUT_W'(32));
    wait_drain("s1_drained");

    // S2: all channels valid, grant order 0,1,2,3,...
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin left[c] = 8; val[c] = 64'(c) << 32; end
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) bd[k*64 +: 64] = {32'((b*8 + k) % 4), 32'((b*8 + k) / 4)};
      push_beat(bd, '1, b == 3);
    end
    stream(0, 100, cyc, acs);
    chk("s2_cycles_for_32", OUT_W'(cyc), OUT_W'(32));
    wait_drain("s2_drained");

    // S3: 3 records then idle timeout
    do_reset();
    left[0] = 3; val[0] = 64'hA0;
    bd = '0;
    for (int k = 0; k < 3; k++) bd[k*64 +: 64] = 64'hA0 + 64'(k);
    push_beat(bd, 64'h0000_0000_00FF_FFFF, 1'b1);
    stream(0, 100, cyc, acs);
    n = 0;
    do begin @(negedge aclk); n++; end while (!m_axis_trace_tvalid && n < 40);
    chk("s3_timeout_latency", OUT_W'(n), OUT_W'(TIMEOUT + 1));
    @(posedge aclk); #1;
    wait_drain("s3_drained");

    // S4: full beat then flush gives a null tlast beat; empty flush is a no-op
    do_reset();
    left[0] = 8; val[0] = 64'hB0;
    for (int k = 0; k < 8; k++) bd[k*64 +: 64] = 64'hB0 + 64'(k);
    push_beat(bd, '1, 1'b0);
    push_beat('0, '0, 1'b1);
    stream(0, 100, cyc, acs);
    pulse_flush();
    wait_drain("s4_null_drained");
    pulse_flush();
    repeat (5) @(posedge aclk);
    #1;
    // flush coinciding with an offered record
    left[0] = 2; val[0] = 64'hC0;
    bd = '0;
    bd[63:0] = 64'hC0; bd[127:64] = 64'hC1;
    push_beat(bd, 64'hFFFF, 1'b1);
    stream(0, 100, cyc, acs);
    left[0] = 6;
    s_trace_valid[0] = 1'b1;
    s_trace_data[63:0] = val[0];
    flush_req = 1'b1;
    @(negedge aclk);
    chk("s4_flush_blocks_grant", OUT_W'(s_trace_ready), '0);
    @(posedge aclk); #1;
    flush_req = 1'b0;
    bd = '0;
    for (int k = 0; k < 6; k++) bd[k*64 +: 64] = 64'hC2 + 64'(k);
    push_beat(bd, 64'h0000_FFFF_FFFF_FFFF, 1'b1);
    stream(0, 100, cyc, acs);
    pulse_flush();
    wait_drain("s4_partial_drained");

    // S5: back-pressure, tready low for 20 cycles
    do_reset();
    left[1] = 32; val[1] = 64'h1000;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) bd[k*64 +: 64] = 64'h1000 + 64'(b*8 + k);
      push_beat(bd, '1, b == 3);
    end
    stream(20, 200, cyc, acs);
    chk("s5_accepts_during_stall", OUT_W'(acs), OUT_W'(16));
    wait_drain("s5_drained");

    // S6: reset with a held beat and fcnt=5
    do_reset();
    left[0] = 13; val[0] = 64'hD0;
    stream(1000, 100, cyc, acs);
    chk("s6_pre_reset_tvalid", OUT_W'(m_axis_trace_tvalid), OUT_W'(1));
    areset = 1'b1;
    #1;
    chk("s6_reset_ctrl", OUT_W'({m_axis_trace_tvalid, m_axis_trace_tlast, m_axis_trace_tkeep, s_trace_ready}), '0);
    chk("s6_reset_tdata", m_axis_trace_tdata, '0);
    @(posedge aclk); #1 areset = 1'b0;
    m_axis_trace_tready = 1'b1;
    @(posedge aclk); #1;
    left[0] = 32; val[0] = 64'hE00;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) bd[k*64 +: 64] = 64'hE00 + 64'(b*8 + k);
      push_beat(bd, '1, b == 3);
    end
    stream(0, 100, cyc, acs);
    wait_drain("s6_drained");

    // S7: channel tag (verbatim in the default build)
    do_reset();
    left[2] = 1; val[2] = '1;
    bd = '0;
`ifdef ROLE_TRACE_CH_TAG_EN
    bd[63:0] = 64'hBFFF_FFFF_FFFF_FFFF;
`else
    bd[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
    push_beat(bd, 64'hFF, 1'b1);
    stream(0, 100, cyc, acs);
    pulse_flush();
    wait_drain("s7_drained");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
